// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU SPI byte link: target codes, FSM states, ID byte.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mcu_pkg;

  localparam logic [7:0] TGT_SYS     = 8'd1;
  localparam logic [7:0] TGT_HID     = 8'd2;
  localparam logic [7:0] TGT_OSD     = 8'd3;
  localparam logic [7:0] TGT_SDC     = 8'd4;
  localparam logic [7:0] ID_BYTE_DEF = 8'h5C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TARGET  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // A target byte addresses a consumer only if it is one of the four codes.
  function automatic logic tgt_valid(input logic [7:0] t);
    return (t >= TGT_SYS) && (t <= TGT_SDC);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detect on the synced value.
// Latency: STAGES clk to o_q, STAGES clk to the edge pulses (edges are one-cycle).
// Backpressure: none; free-running sampler.
// Ports: clk/reset_n (sync, active-low), i_d async pin, o_q synced level,
//        o_rise/o_fall one-cycle pulses on synced transitions.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/mcu_spi.sv
// Mode-0 SPI slave: first byte of a frame selects a target, later bytes strobe that consumer; replies go out on MISO.
// Latency: pulse 1 clk after the synced 8th rising sclk edge (SYNC_STAGES+1 clk from the pin edge).
// Backpressure: none; consumers must take each byte on its one-cycle pulse, reply byte sampled 1 clk after it.
// Ports: clk, reset_n (sync, active-low); spi_csn/spi_sclk/spi_mosi/spi_miso MCU pins;
//        mcu_din reply byte; mcu_start + four target strobes (one-cycle); mcu_data last received byte.
module mcu_spi
  import mcu_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = ID_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] mcu_din,
  output logic       mcu_start,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  output logic [7:0] mcu_data
);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_csn_s, w_csn_rise_unused, w_csn_fall;
  logic w_mosi_s, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .i_d(spi_sclk),
    .o_q(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .reset_n(reset_n), .i_d(spi_csn),
    .o_q(w_csn_s), .o_rise(w_csn_rise_unused), .o_fall(w_csn_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_d(spi_mosi),
    .o_q(w_mosi_s), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_e     r_state, w_state_nxt;
  logic       r_armed;
  logic [6:0] r_rx;      // only 7 bits kept: the 8th arrives with the completing edge
  logic [2:0] r_cnt;
  logic [7:0] r_tgt;
  logic [7:0] r_tx;
  logic [7:0] r_data;
  logic       r_start, r_sys, r_hid, r_osd, r_sdc;

  logic       w_active, w_byte_done, w_enter, w_pulse_any;
  logic [7:0] w_byte;

  assign w_active    = (r_state != IDLE);
  assign w_byte      = {r_rx, w_mosi_s};
  assign w_byte_done = w_sclk_rise && w_active && (r_cnt == 3'd7);
  assign w_enter     = (r_state == IDLE) && (w_state_nxt == TARGET);
  assign w_pulse_any = r_start | r_sys | r_hid | r_osd | r_sdc;

  always_comb begin
    w_state_nxt = r_state;
    if (w_csn_s) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_csn_fall && r_armed) w_state_nxt = TARGET;
        TARGET:  if (w_byte_done)           w_state_nxt = PAYLOAD;
        PAYLOAD: w_state_nxt = PAYLOAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_rx    <= '0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_tx    <= '0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_sys   <= 1'b0;
      r_hid   <= 1'b0;
      r_osd   <= 1'b0;
      r_sdc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= r_armed | w_csn_s;
      r_start <= 1'b0;
      r_sys   <= 1'b0;
      r_hid   <= 1'b0;
      r_osd   <= 1'b0;
      r_sdc   <= 1'b0;

      // Keyed on the registered state so a byte completing in the same
      // cycle csn is seen high is still delivered.
      if (w_sclk_rise && w_active) begin
        r_rx  <= w_byte[6:0];
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_byte_done) begin
        r_data <= w_byte;
        if (r_state == TARGET) begin
          r_start <= 1'b1;
          r_tgt   <= w_byte;
        end else begin
          case (r_tgt)
            TGT_SYS: r_sys <= 1'b1;
            TGT_HID: r_hid <= 1'b1;
            TGT_OSD: r_osd <= 1'b1;
            TGT_SDC: r_sdc <= 1'b1;
            default: ;
          endcase
        end
      end

      // The falling edge that closes a byte (counter back at 0) must not
      // shift: the reply loaded after the pulse has to keep its MSB on MISO
      // for the first rising edge of the next byte.
      if (w_sclk_fall && w_active && (r_cnt != 3'd0))
        r_tx <= {r_tx[6:0], 1'b0};
      if (w_pulse_any)
        r_tx <= tgt_valid(r_tgt) ? mcu_din : 8'h00;
      if (w_enter) begin
        r_tx  <= ID_BYTE;
        r_cnt <= '0;
      end

      // Deselect drops any partial byte and stale reply data.
      if (w_csn_s) begin
        r_cnt <= '0;
        r_tx  <= '0;
      end
    end
  end

  assign spi_miso       = r_tx[7] & ~w_csn_s;
  assign mcu_start      = r_start;
  assign mcu_sys_strobe = r_sys;
  assign mcu_hid_strobe = r_hid;
  assign mcu_osd_strobe = r_osd;
  assign mcu_sdc_strobe = r_sdc;
  assign mcu_data       = r_data;

endmodule

// File: tb/tb_mcu_spi.sv
// Bench for mcu_spi: drives mode-0 SPI frames, records every pulse as (kind, data)
// and every MISO byte, and compares them with a frame-level reference model.
module tb_mcu_spi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_csn, spi_sclk, spi_mosi, spi_miso;
  logic [7:0] mcu_din;
  logic       mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
  logic [7:0] mcu_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcu_spi #(.SYNC_STAGES(2), .ID_BYTE(8'h5C)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mcu_din(mcu_din),
    .mcu_start(mcu_start), .mcu_sys_strobe(mcu_sys_strobe), .mcu_hid_strobe(mcu_hid_strobe),
    .mcu_osd_strobe(mcu_osd_strobe), .mcu_sdc_strobe(mcu_sdc_strobe),
    .mcu_data(mcu_data)
  );

  // Event = {kind, data}; kind 0 = start, 1..4 = sys/hid/osd/sdc strobe.
  logic [10:0] ev_q[$];
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (mcu_start)      ev_q.push_back({3'd0, mcu_data});
    if (mcu_sys_strobe) ev_q.push_back({3'd1, mcu_data});
    if (mcu_hid_strobe) ev_q.push_back({3'd2, mcu_data});
    if (mcu_osd_strobe) ev_q.push_back({3'd3, mcu_data});
    if (mcu_sdc_strobe) ev_q.push_back({3'd4, mcu_data});
  end

  // Current frame: bytes sent, reply byte offered during each, MISO seen, expected MISO.
  logic [7:0] fb[0:7];
  logic [7:0] fd[0:7];
  logic [7:0] fm[0:7];
  logic [7:0] exp_miso[0:7];
  int         fn;

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: first byte is the target, always announced by start;
  // later bytes strobe the target only if it is 1..4. MISO carries the ID byte
  // first, then each byte carries the reply offered during the previous byte.
  task automatic model_frame();
    logic [7:0] t;
    bit ok;
    t  = fb[0];
    ok = (t >= 8'd1) && (t <= 8'd4);
    exp_q.push_back({3'd0, t});
    exp_miso[0] = 8'h5C;
    for (int k = 1; k < fn; k++) begin
      if (ok) exp_q.push_back({t[2:0], fb[k]});
      exp_miso[k] = ok ? fd[k-1] : 8'h00;
    end
  endtask

  // Mode 0: data changes while sclk low, MCU samples MISO at the rising edge.
  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (8) @(negedge clk);
      r[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int gap);
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < fn; k++) begin
      mcu_din = fd[k];
      spi_byte(fb[k], 8, fm[k]);
    end
    repeat (8) @(negedge clk);
    spi_csn = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    mcu_din  = 8'h00;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      spi_csn  = 1'($urandom);
      spi_sclk = 1'($urandom);
      spi_mosi = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
           spi_miso, mcu_data} !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got start=%b strb=%b%b%b%b miso=%b data=%h, required all 0",
                 i, mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
                 spi_miso, mcu_data);
      end
    end
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    reset_n  = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (ev_q.size() !== 0 || mcu_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d pulses data=%h, required 0 pulses data=00", ev_q.size(), mcu_data);
    end
  endtask

  task automatic test_osd();
    fn = 3;
    fb[0] = 8'h03; fb[1] = 8'h12; fb[2] = 8'h34;
    for (int k = 0; k < 3; k++) fd[k] = 8'($urandom);
    ev_q.delete(); exp_q.delete();
    model_frame();
    run_frame(12);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL osd_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL osd_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL osd_miso[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
    n_checks++;
    if (mcu_data !== 8'h34) begin
      n_fail++; $display("FAIL osd_data_hold: got %h, required 34", mcu_data);
    end
  endtask

  task automatic test_miso();
    fn = 3;
    fb[0] = 8'h01; fb[1] = 8'($urandom); fb[2] = 8'($urandom);
    for (int k = 0; k < 3; k++) fd[k] = 8'hC3;
    ev_q.delete(); exp_q.delete();
    model_frame();
    run_frame(12);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL miso_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL miso_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL miso_byte[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
  endtask

  task automatic test_unknown_target();
    fn = 2;
    fb[0] = 8'h07; fb[1] = 8'hAA;
    fd[0] = 8'($urandom) | 8'h80; fd[1] = 8'($urandom);
    ev_q.delete(); exp_q.delete();
    model_frame();
    run_frame(12);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL unknown_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL unknown_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL unknown_miso[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] junk;
    ev_q.delete(); exp_q.delete();
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    spi_byte(8'($urandom), 5, junk);
    repeat (8) @(negedge clk);
    spi_csn = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ev_q.size() !== 0) begin
      n_fail++; $display("FAIL abort_no_pulse: got %0d pulses, required 0", ev_q.size());
    end
    fn = 2;
    fb[0] = 8'h02; fb[1] = 8'h55;
    fd[0] = 8'($urandom); fd[1] = 8'($urandom);
    model_frame();
    run_frame(12);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL abort_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL abort_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL abort_miso[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
  endtask

  // csn rises in the same clk as the 8th rising edge of the payload byte.
  task automatic test_csn_at_completion();
    fn = 2;
    fb[0] = 8'h04; fb[1] = 8'($urandom);
    fd[0] = 8'($urandom); fd[1] = 8'($urandom);
    ev_q.delete(); exp_q.delete();
    model_frame();
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    mcu_din = fd[0];
    spi_byte(fb[0], 8, fm[0]);
    mcu_din = fd[1];
    spi_byte(fb[1], 7, fm[1]);
    spi_mosi = fb[1][0];
    repeat (8) @(negedge clk);
    fm[1][0] = spi_miso;
    spi_sclk = 1'b1;
    spi_csn  = 1'b1;
    repeat (8) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL edge_csn_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL edge_csn_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL edge_csn_miso[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] junk;
    fn = 2;
    fb[0] = 8'h02; fb[1] = 8'($urandom);
    fd[0] = 8'($urandom); fd[1] = 8'($urandom);
    ev_q.delete(); exp_q.delete();
    model_frame();
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mcu_din = fd[k];
      spi_byte(fb[k], 8, fm[k]);
    end
    spi_byte(8'($urandom), 3, junk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    spi_byte(8'($urandom), 5, junk);
    spi_byte(8'($urandom), 8, junk);
    spi_byte(8'($urandom), 8, junk);
    repeat (8) @(negedge clk);
    spi_csn = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    fn = 3;
    fb[0] = 8'h03; fb[1] = 8'($urandom); fb[2] = 8'($urandom);
    for (int k = 0; k < 3; k++) fd[k] = 8'($urandom);
    ev_q.delete(); exp_q.delete();
    model_frame();
    run_frame(12);
    n_checks++;
    if (ev_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_new_count: got %0d pulses, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_new_event[%0d]: got %h, required %h", i, ev_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < fn; k++) begin
      n_checks++;
      if (fm[k] !== exp_miso[k]) begin
        n_fail++; $display("FAIL rstmid_new_miso[%0d]: got %h, required %h", k, fm[k], exp_miso[k]);
      end
    end
  endtask

  // Random frames with short csn-high gaps between them.
  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      fn = int'($urandom_range(1, 4));
      fb[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      for (int k = 1; k < fn; k++) fb[k] = 8'($urandom);
      for (int k = 0; k < fn; k++) fd[k] = 8'($urandom);
      ev_q.delete(); exp_q.delete();
      model_frame();
      run_frame(int'($urandom_range(3, 20)));
      n_checks++;
      if (ev_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL b2b_count[f%0d]: got %0d pulses, required %0d", f, ev_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
        n_checks++;
        if (ev_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_event[f%0d][%0d]: got %h, required %h", f, i, ev_q[i], exp_q[i]);
        end
      end
      for (int k = 0; k < fn; k++) begin
        n_checks++;
        if (fm[k] !== exp_miso[k]) begin
          n_fail++; $display("FAIL b2b_miso[f%0d][%0d]: got %h, required %h", f, k, fm[k], exp_miso[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_osd();
    test_miso();
    test_unknown_target();
    test_abort();
    test_csn_at_completion();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
